dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Two-port arbiter sharing the single-port data memory between requester 0 (CPU load/store)
//   and requester 1 (DMA/debug loader). Sits between both masters and the data memory; drives
//   its WE/WD/Address and samples its combinational RD. One access per cycle, round-robin
//   fairness, optional lock for atomic multi-word bursts, registered read response.
// PARAMETERS
//   ADDR_W  10  byte-address width; must equal the data memory addressWidth
//   DATA_W  32  data width; must equal the data memory dataWidth
// PORTS
//   clk       in   1       rising-edge clock
//   rst_n     in   1       asynchronous active-low reset
//   req0/1    in   1       access request; held with attributes until gnt
//   we0/1     in   1       1 = write, 0 = read
//   addr0/1   in   ADDR_W  byte address (word index = addr[ADDR_W-1:2])
//   wdata0/1  in   DATA_W  write data
//   lock0/1   in   1       keep ownership after this grant
//   gnt0/1    out  1       combinational grant; access performed this cycle
//   rvalid0/1 out  1       response valid, one cycle after gnt (reads and writes)
//   rdata0/1  out  DATA_W  registered read data; 0 for write responses
//   mem_we    out  1       to data memory WE
//   mem_addr  out  ADDR_W  to data memory Address
//   mem_wd    out  DATA_W  to data memory WD
//   mem_rd    in   DATA_W  from data memory RD (combinational)
// BEHAVIOUR
//   - States: IDLE (no owner), OWN0, OWN1 (locked owner). Reset -> IDLE, last_gnt = 1
//     (so requester 0 wins first tie); all outputs 0 during and right after reset.
//   - IDLE: only one req -> grant it. Both -> grant the one NOT in last_gnt. None -> no grant,
//     mem_we = 0, mem_addr/mem_wd = 0.
//   - Grant with lock=1 -> next state OWN<n>. OWNn: only requester n granted, whenever reqn=1;
//     other requester stalls. OWNn exits to IDLE at the first granted access with lockn=0, or
//     in any cycle with reqn=0 (lock without req releases ownership).
//   - last_gnt updates on every grant. At most one gnt per cycle; gnt never asserted without req.
//   - Mux: mem_we = gnt & we_sel; mem_addr/mem_wd from granted requester. Write commits at the
//     posedge ending the grant cycle.
//   - Response: rvalid<n> high exactly one cycle after gnt<n>; rdata<n> = mem_rd captured at
//     that edge for reads, 0 for writes. Back-to-back grants give back-to-back rvalids.
//   - Read then write to same word in consecutive cycles: read returns old data.
//   - Async reset mid-access: write in that cycle may be lost; state, last_gnt, rvalid, rdata cleared.
// CONFIGURATION
//   DMEM_ARB_FIXED_PRIO_EN defined: requester 0 always wins contention (last_gnt ignored; lock
//   still honoured). Undefined: round-robin as above.
// STRUCTURE
//   Package dmem_arb_pkg: state enum {IDLE, OWN0, OWN1}, requester-index constants REQ_CPU=0,
//   REQ_DMA=1. Sub-module dmem_arb_rr (2-way grant logic with last_gnt pointer) instantiated by
//   the top; mux, FSM and response registers in the top.
// TESTING
//   - Reset: rst_n=0 with both reqs high -> no gnt, rvalid0/1=0, rdata=0; release -> gnt0 first.
//   - Single write/read: req0 we0=1 addr=0x010 wdata=0xDEADBEEF, then read 0x010 ->
//     rvalid0 next cycle, rdata0=0xDEADBEEF.
//   - Contention: req0 and req1 held for 4 cycles, no lock -> gnt 0,1,0,1; with
//     DMEM_ARB_FIXED_PRIO_EN -> gnt0 every cycle, gnt1 never.
//   - Lock burst: req1 lock1=1 for 3 writes 0x100/0x104/0x108 while req0 high -> gnt1 x3,
//     lock1=0 on 3rd, gnt0 on 4th cycle.
//   - Read-after-write race: gnt0 read 0x020 (old 0x11) then gnt1 write 0x020=0x22 ->
//     rdata0=0x11, subsequent read returns 0x22.
//   - Reset mid-lock: assert rst_n=0 in OWN1 -> state IDLE, outputs 0, next contention grants 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned REQ_CPU = 0;
    localparam int unsigned REQ_DMA = 1;

    // IDLE: no owner; OWN0/OWN1: requester holds the memory via lock
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_arb_rr.sv
// Two-way grant selection with a last-granted pointer for round-robin ties.
// DMEM_ARB_FIXED_PRIO_EN: requester 0 always wins a tie (pointer not consulted).
module dmem_arb_rr
    import dmem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] allow,
    output logic [NUM_REQ-1:0] gnt_c
);

    logic               last_gnt_q;
    logic               last_gnt_d;
    logic [NUM_REQ-1:0] elig;

    // Pick at most one eligible requester; pointer tracks the latest grant
    always_comb begin
        elig       = req & allow;
        gnt_c      = '0;
        last_gnt_d = last_gnt_q;
        if (elig == 2'b11) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            gnt_c[REQ_CPU] = 1'b1;
`else
            if (last_gnt_q) gnt_c[REQ_CPU] = 1'b1;
            else            gnt_c[REQ_DMA] = 1'b1;
`endif
        end else begin
            gnt_c = elig;
        end
        if (gnt_c[REQ_CPU])      last_gnt_d = 1'b0;
        else if (gnt_c[REQ_DMA]) last_gnt_d = 1'b1;
    end

    // Pointer resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_gnt_q <= 1'b1;
        else        last_gnt_q <= last_gnt_d;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: one access per
// cycle, lockable ownership for bursts, registered read response.
// DMEM_ARB_FIXED_PRIO_EN: fixed priority to requester 0 instead of round-robin.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              lock0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] allow;
    logic [NUM_REQ-1:0] gnt_c;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata0_q, rdata0_d;
    logic [DATA_W-1:0]  rdata1_q, rdata1_d;

    dmem_arb_rr u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({req1, req0}),
        .allow (allow),
        .gnt_c (gnt_c)
    );

    assign gnt0 = gnt_c[REQ_CPU];
    assign gnt1 = gnt_c[REQ_DMA];

    // Ownership FSM: restricts eligibility while a requester holds the lock
    always_comb begin
        state_d = state_q;
        allow   = '0;
        case (state_q)
            IDLE: begin
                allow = 2'b11;
                if (gnt0 && lock0)      state_d = OWN0;
                else if (gnt1 && lock1) state_d = OWN1;
            end
            OWN0: begin
                allow = 2'b01;
                if (!req0 || (gnt0 && !lock0)) state_d = IDLE;
            end
            OWN1: begin
                allow = 2'b10;
                if (!req1 || (gnt1 && !lock1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // No grants while reset is asserted
        if (!rst_n) allow = '0;
    end

    // Route the granted requester onto the memory port
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (gnt0) begin
            mem_we   = we0;
            mem_addr = addr0;
            mem_wd   = wdata0;
        end else if (gnt1) begin
            mem_we   = we1;
            mem_addr = addr1;
            mem_wd   = wdata1;
        end
    end

    // Response: valid follows every grant; data only for reads
    always_comb begin
        rvalid_d = gnt_c;
        rdata0_d = (gnt0 && !we0) ? mem_rd : '0;
        rdata1_d = (gnt1 && !we1) ? mem_rd : '0;
    end

    // State and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rvalid_q <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign rvalid0 = rvalid_q[REQ_CPU];
    assign rvalid1 = rvalid_q[REQ_DMA];
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk, rst_n;
    logic req0, we0, lock0, req1, we1, lock1;
    logic [ADDR_W-1:0] addr0, addr1, mem_addr;
    logic [DATA_W-1:0] wdata0, wdata1, rdata0, rdata1, mem_wd, mem_rd;
    logic gnt0, gnt1, rvalid0, rvalid1, mem_we;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] mem [0:255];

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory: combinational read, posedge write
    assign mem_rd = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wd;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; we0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        req0 = 1; req1 = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt got=%b%b exp=00", gnt1, gnt0); end
        checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b%b exp=00", rvalid1, rvalid0); end
        checks++; if (rdata0 !== '0 || rdata1 !== '0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0", rdata0, rdata1); end
        checks++; if (mem_we !== 1'b0 || mem_addr !== '0) begin errors++; $display("FAIL reset_mem got we=%b addr=%h exp=0", mem_we, mem_addr); end
        rst_n = 1;
        #1;
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL reset_first_gnt got=%b%b exp=01", gnt1, gnt0); end
        tick();
        idle_inputs();
        checks++; if (rvalid0 !== 1'b1) begin errors++; $display("FAIL reset_first_rvalid got=%b exp=1", rvalid0); end
        tick();
    endtask

    task automatic test_write_read();
        do_reset();
        req0 = 1; we0 = 1; addr0 = 10'h010; wdata0 = 32'hDEADBEEF;
        #1;
        checks++; if (gnt0 !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL wr_gnt got gnt0=%b we=%b exp=1/1", gnt0, mem_we); end
        checks++; if (mem_addr !== 10'h010 || mem_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mux got addr=%h wd=%h exp=010/deadbeef", mem_addr, mem_wd); end
        tick();
        checks++; if (rvalid0 !== 1'b1 || rdata0 !== '0) begin errors++; $display("FAIL wr_resp got v=%b d=%h exp=1/0", rvalid0, rdata0); end
        we0 = 0;
        tick();
        req0 = 0;
        checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_resp got v=%b d=%h exp=1/deadbeef", rvalid0, rdata0); end
        tick();
        checks++; if (rvalid0 !== 1'b0 || rdata0 !== '0) begin errors++; $display("FAIL rd_idle got v=%b d=%h exp=0/0", rvalid0, rdata0); end
    endtask

    task automatic test_contention();
        logic e0;
        do_reset();
        req0 = 1; addr0 = 10'h000; req1 = 1; addr1 = 10'h004;
        for (int i = 0; i < 4; i++) begin
            e0 = FIXED ? 1'b1 : ((i % 2) == 0);
            #1;
            checks++; if (gnt0 !== e0 || gnt1 !== !e0) begin errors++; $display("FAIL contend_%0d got=%b%b exp=%b%b", i, gnt1, gnt0, !e0, e0); end
            tick();
            checks++; if (rvalid0 !== e0 || rvalid1 !== !e0) begin errors++; $display("FAIL contend_rv_%0d got=%b%b exp=%b%b", i, rvalid1, rvalid0, !e0, e0); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_lock_burst();
        do_reset();
        req1 = 1; we1 = 1; lock1 = 1; addr1 = 10'h100; wdata1 = 32'hA0A0_0001;
        #1;
        checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL lock_g1_0 got=%b exp=1", gnt1); end
        tick();
        req0 = 1; addr0 = 10'h104;
        addr1 = 10'h104; wdata1 = 32'hA0A0_0002;
        #1;
        checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL lock_g1_1 got=%b%b exp=10", gnt1, gnt0); end
        tick();
        addr1 = 10'h108; wdata1 = 32'hA0A0_0003; lock1 = 0;
        #1;
        checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL lock_g1_2 got=%b%b exp=10", gnt1, gnt0); end
        tick();
        req1 = 0; we1 = 0;
        #1;
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL lock_g0_3 got=%b%b exp=01", gnt1, gnt0); end
        tick();
        req0 = 0;
        checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hA0A0_0002) begin errors++; $display("FAIL lock_data got=%h exp=a0a00002", rdata0); end
        checks++; if (mem[8'h42] !== 32'hA0A0_0003) begin errors++; $display("FAIL lock_mem got=%h exp=a0a00003", mem[8'h42]); end
        tick();
    endtask

    task automatic test_raw_race();
        mem[8'h08] = 32'h11;
        do_reset();
        req0 = 1; addr0 = 10'h020;
        #1;
        checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL raw_g0 got=%b exp=1", gnt0); end
        tick();
        req0 = 0; req1 = 1; we1 = 1; addr1 = 10'h020; wdata1 = 32'h22;
        checks++; if (rdata0 !== 32'h11) begin errors++; $display("FAIL raw_old got=%h exp=11", rdata0); end
        #1;
        checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL raw_g1 got=%b exp=1", gnt1); end
        tick();
        idle_inputs();
        req0 = 1; addr0 = 10'h020;
        checks++; if (rvalid1 !== 1'b1 || rdata1 !== '0) begin errors++; $display("FAIL raw_wresp got v=%b d=%h exp=1/0", rvalid1, rdata1); end
        tick();
        req0 = 0;
        checks++; if (rdata0 !== 32'h22) begin errors++; $display("FAIL raw_new got=%h exp=22", rdata0); end
        tick();
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        req1 = 1; lock1 = 1; addr1 = 10'h0C0;
        tick();
        req0 = 1;
        #1;
        checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL midlock_own got=%b%b exp=10", gnt1, gnt0); end
        tick();
        rst_n = 0;
        #1;
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || rvalid1 !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL midlock_clear got g=%b%b rv1=%b we=%b exp=0", gnt1, gnt0, rvalid1, mem_we); end
        tick();
        lock1 = 0;
        rst_n = 1;
        #1;
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL midlock_after got=%b%b exp=01", gnt1, gnt0); end
        tick();
        idle_inputs();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_write_read();
        test_contention();
        test_lock_burst();
        test_raw_race();
        test_reset_mid_lock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
